// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: stall/redirect from execute, instruction memory port,
// and the IF/ID register contents with status.
interface fetch_unit_if #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
);
  logic              stall;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_target;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_instr;
  logic              if_valid;
  logic [31:0]       if_instr;
  logic [ADDR_W-1:0] if_pc;
  logic              halted;
  logic [CNT_W-1:0]  issue_count;

  // Environment side: drives control and memory data, observes fetch outputs.
  modport master (
    output stall, redirect_valid, redirect_target, imem_instr,
    input  imem_addr, if_valid, if_instr, if_pc, halted, issue_count
  );

  // Fetch unit side.
  modport slave (
    input  stall, redirect_valid, redirect_target, imem_instr,
    output imem_addr, if_valid, if_instr, if_pc, halted, issue_count
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, predecodes JUMP, halts on a zero word,
// accepts redirects from execute and fills the IF/ID register.
//
// state | meaning
// RUN   | fetching one word per cycle
// HALT  | zero word seen; frozen until redirect or reset
module fetch_unit #(
  parameter int ADDR_W   = 8,
  parameter int RESET_PC = 0,
  parameter int CNT_W    = 16
) (
  input  logic         clk_i,
  input  logic         reset_i,
  fetch_unit_if.slave  bus
);

  typedef enum logic {ST_RUN = 1'b0, ST_HALT = 1'b1} state_t;

  localparam logic [3:0] OP_JUMP = 4'b1000;

  state_t            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;
  logic              if_valid_q;
  logic [31:0]       if_instr_q;
  logic [ADDR_W-1:0] if_pc_q;
  logic              halted_q;
  logic [CNT_W-1:0]  issue_count_q;
  logic [CNT_W-1:0]  issue_count_d;
  logic              is_halt_word;
  logic              is_jump;
  logic [ADDR_W-1:0] jump_target;

  // Predecode of the word currently returned by memory, plus the increments.
  always_comb begin
    is_halt_word  = (bus.imem_instr == 32'h0000_0000);
    is_jump       = (bus.imem_instr[31:28] == OP_JUMP);
    jump_target   = bus.imem_instr[ADDR_W-1:0];
    pc_d          = pc_q + 1'b1;
    issue_count_d = (&issue_count_q) ? issue_count_q : issue_count_q + 1'b1;
  end

  // Fetch FSM with PC and IF/ID register; branches ordered by priority.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= ST_RUN;
      pc_q          <= ADDR_W'(RESET_PC);
      if_valid_q    <= 1'b0;
      if_instr_q    <= '0;
      if_pc_q       <= '0;
      halted_q      <= 1'b0;
      issue_count_q <= '0;
    end else if (bus.redirect_valid) begin
      // Redirect beats stall, halt, and any JUMP/halt word in flight.
      state_q    <= ST_RUN;
      halted_q   <= 1'b0;
      pc_q       <= bus.redirect_target;
      if_valid_q <= 1'b0;
    end else if (state_q == ST_HALT) begin
      if_valid_q <= 1'b0;
    end else if (bus.stall) begin
      // Hold everything.
    end else if (is_halt_word) begin
      state_q    <= ST_HALT;
      halted_q   <= 1'b1;
      if_valid_q <= 1'b0;
    end else if (is_jump) begin
      // JUMP is resolved here and never issued; one bubble.
      pc_q       <= jump_target;
      if_valid_q <= 1'b0;
    end else begin
      if_instr_q    <= bus.imem_instr;
      if_pc_q       <= pc_q;
      if_valid_q    <= 1'b1;
      pc_q          <= pc_d;
      issue_count_q <= issue_count_d;
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.if_valid    = if_valid_q;
  assign bus.if_instr    = if_instr_q;
  assign bus.if_pc       = if_pc_q;
  assign bus.halted      = halted_q;
  assign bus.issue_count = issue_count_q;

endmodule
